// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the NOP encoding and the IF/ID entry layout.
package pipe_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } if_id_entry_t;

endpackage

// File: rtl/if_id_storage.sv
// IF/ID entry storage: register array, synchronous write, asynchronous read.
module if_id_storage #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue with valid/ready on both sides and single-cycle flush.
module if_id_queue #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = pipe_pkg::ADDR_W,
    parameter int unsigned INST_W = pipe_pkg::INST_W
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_pc,
    input  logic [INST_W-1:0]          in_inst,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [INST_W-1:0]          out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    import pipe_pkg::*;

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DATA_W = ADDR_W + INST_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             push, pop;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign wr_entry = '{pc: in_pc, inst: in_inst};

    if_id_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk_i   (Clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Handshakes and next-state for pointers, occupancy and the registered ready.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;

        push = in_valid & in_ready_q & ~flush;
        pop  = (count_q != '0) & out_ready & ~flush;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        // Ready depends only on next occupancy, never on out_ready this cycle.
        in_ready_d = (count_d < CNT_W'(DEPTH));
    end

    // State register with asynchronous clear.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Head presentation: an empty queue shows a NOP bubble.
    assign in_ready  = in_ready_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? rd_entry.pc   : '0;
    assign out_inst  = out_valid ? rd_entry.inst : INST_W'(NOP_INST);

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2 main instance, DEPTH=3 instance for wrap).
module tb_if_id_queue;
    import pipe_pkg::*;

    logic        Clk;
    logic        Rst;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_inst, out_pc, out_inst;
    logic [1:0]  count;

    logic        in_valid3, in_ready3, flush3, out_valid3, out_ready3;
    logic [31:0] in_pc3, in_inst3, out_pc3, out_inst3;
    logic [1:0]  count3;

    int total = 0;
    int bad   = 0;

    if_id_entry_t sb[$];
    if_id_entry_t q3[$];

    if_id_queue #(.DEPTH(2)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .count(count)
    );

    if_id_queue #(.DEPTH(3)) u_dut3 (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_pc(in_pc3), .in_inst(in_inst3),
        .flush(flush3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_pc(out_pc3), .out_inst(out_inst3),
        .count(count3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the DEPTH=2 instance; the queue model predicts acceptance and pops.
    task automatic cycle2(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic rdy, input logic fl);
        if_id_entry_t e;
        logic push_m, pop_m;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        e.pc      = pc;
        e.inst    = inst;
        #1;
        check("pre_valid", 64'(out_valid), 64'(sb.size() != 0));
        push_m = v && (sb.size() < 2) && !fl;
        pop_m  = (sb.size() != 0) && rdy && !fl;
        if (pop_m) begin
            check("pop_pc",   64'(out_pc),   64'(sb[0].pc));
            check("pop_inst", 64'(out_inst), 64'(sb[0].inst));
        end
        @(posedge Clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop_m) void'(sb.pop_front());
            if (push_m) sb.push_back(e);
        end
        check("count",     64'(count),     64'(sb.size()));
        check("in_ready",  64'(in_ready),  64'(sb.size() < 2));
        check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("head_pc",   64'(out_pc),   64'(sb[0].pc));
            check("head_inst", 64'(out_inst), 64'(sb[0].inst));
        end else begin
            check("bubble_pc",   64'(out_pc),   64'(0));
            check("bubble_inst", 64'(out_inst), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        int popped;
        if_id_entry_t e3;

        Rst = 1'b1;
        in_valid = 0; in_pc = 0; in_inst = 0; flush = 0; out_ready = 0;
        in_valid3 = 0; in_pc3 = 0; in_inst3 = 0; flush3 = 0; out_ready3 = 0;

        // Power-on reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_count",    64'(count),     64'(0));
        check("rst_in_ready", 64'(in_ready),  64'(1));
        check("rst_valid",    64'(out_valid), 64'(0));
        check("rst_pc",       64'(out_pc),    64'(0));
        check("rst_inst",     64'(out_inst),  64'(0));
        check("rst3_count",   64'(count3),    64'(0));
        Rst = 1'b0;

        // Single-entry latency
        cycle2(1'b1, 32'd4, 32'h0232_8820, 1'b0, 1'b0);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_pc",    64'(out_pc),    64'(4));
        check("lat_inst",  64'(out_inst),  64'(32'h0232_8820));
        check("lat_count", 64'(count),     64'(1));

        // Asynchronous reset mid-cycle with one entry held
        #3;
        Rst = 1'b1;
        #1;
        check("arst_count",    64'(count),     64'(0));
        check("arst_valid",    64'(out_valid), 64'(0));
        check("arst_inst",     64'(out_inst),  64'(0));
        check("arst_in_ready", 64'(in_ready),  64'(1));
        sb.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        // Fill to full, refused third offer, pop-only when full
        cycle2(1'b1, 32'd4,  32'hA5C3_0004, 1'b0, 1'b0);
        cycle2(1'b1, 32'd8,  32'hA5C3_0008, 1'b0, 1'b0);
        check("full_count", 64'(count),    64'(2));
        check("full_ready", 64'(in_ready), 64'(0));
        cycle2(1'b1, 32'd12, 32'hA5C3_000C, 1'b0, 1'b0);
        check("refuse_count", 64'(count), 64'(2));
        cycle2(1'b1, 32'd12, 32'hA5C3_000C, 1'b1, 1'b0);
        check("popfull_count", 64'(count),  64'(1));
        check("popfull_pc",    64'(out_pc), 64'(8));

        // Simultaneous push and pop at count=1
        cycle2(1'b1, 32'd16, 32'hA5C3_0010, 1'b1, 1'b0);
        check("pp_count", 64'(count),  64'(1));
        check("pp_pc",    64'(out_pc), 64'(16));

        // Flush with concurrent push and pop at count=2
        cycle2(1'b1, 32'd20, 32'hA5C3_0014, 1'b0, 1'b0);
        check("preflush_count", 64'(count), 64'(2));
        cycle2(1'b1, 32'd24, 32'hA5C3_0018, 1'b1, 1'b1);
        check("flush_count", 64'(count),     64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        cycle2(1'b1, 32'h30, 32'hA5C3_0030, 1'b0, 1'b0);
        check("postflush_pc", 64'(out_pc), 64'(32'h30));
        cycle2(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("drain_count", 64'(count), 64'(0));

        // Wrap on DEPTH=3: seven back-to-back push/pop pairs
        popped = 0;
        for (int k = 1; k <= 8; k++) begin
            in_valid3  = (k <= 7);
            in_pc3     = 32'(4 * k);
            in_inst3   = {16'hB00B, 16'(4 * k)};
            out_ready3 = 1'b1;
            #1;
            if (q3.size() != 0) begin
                check("wrap_pc",   64'(out_pc3),   64'(q3[0].pc));
                check("wrap_inst", 64'(out_inst3), 64'(q3[0].inst));
                check("wrap_seq",  64'(out_pc3),   64'(4 * (popped + 1)));
                popped++;
                void'(q3.pop_front());
            end
            if (k <= 7) begin
                e3.pc   = in_pc3;
                e3.inst = in_inst3;
                q3.push_back(e3);
            end
            @(posedge Clk);
            #1;
            check("wrap_count", 64'(count3), 64'(q3.size()));
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;
        check("wrap_total", 64'(popped),     64'(7));
        check("wrap_empty", 64'(out_valid3), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
